// File: rtl/seq_mag_comp.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per cycle, unsigned or two's-complement.
// Latency 1..NCHUNK cycles from accept to out_valid; one compare in flight, result held until out_ready.
module seq_mag_comp #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int CW = $clog2(NCHUNK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             agtb,
    output logic             aeqb,
    output logic             altb,
    output logic [CW-1:0]    out_cycles
);

    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
        $error("seq_mag_comp: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    idx_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CHUNK-1:0] hi_a, hi_b;
    logic             out_valid_q, agtb_q, aeqb_q, altb_q;
    logic [CW-1:0]    out_cycles_q;

    // Operands shift left as chunks match, so the live chunk is always the top slice.
    assign hi_a  = a_q[WIDTH-1 -: CHUNK];
    assign hi_b  = b_q[WIDTH-1 -: CHUNK];
    assign cnt_d = cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            agtb_q       <= 1'b0;
            aeqb_q       <= 1'b0;
            altb_q       <= 1'b0;
            out_cycles_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Flipping the sign bit maps two's-complement order onto unsigned order.
                        a_q     <= {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
                        b_q     <= {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
                        idx_q   <= IW'(NCHUNK - 1);
                        cnt_q   <= '0;
                        state_q <= CMP;
                    end
                end
                CMP: begin
                    cnt_q <= cnt_d;
                    if (hi_a != hi_b) begin
                        agtb_q       <= (hi_a > hi_b);
                        altb_q       <= (hi_a < hi_b);
                        out_valid_q  <= 1'b1;
                        out_cycles_q <= cnt_d;
                        state_q      <= DONE;
                    end else if (idx_q == '0) begin
                        aeqb_q       <= 1'b1;
                        out_valid_q  <= 1'b1;
                        out_cycles_q <= cnt_d;
                        state_q      <= DONE;
                    end else begin
                        idx_q <= idx_q - IW'(1);
                        a_q   <= a_q << CHUNK;
                        b_q   <= b_q << CHUNK;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q  <= 1'b0;
                        agtb_q       <= 1'b0;
                        aeqb_q       <= 1'b0;
                        altb_q       <= 1'b0;
                        out_cycles_q <= '0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE) && rst_n;
    assign out_valid  = out_valid_q;
    assign agtb       = agtb_q;
    assign aeqb       = aeqb_q;
    assign altb       = altb_q;
    assign out_cycles = out_cycles_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Bench for seq_mag_comp: directed and random 16/4 compares plus exhaustive 4/1 compares under back-pressure.
module tb_seq_mag_comp;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        iv16, ir16, sm16, ov16, or16, gt16, eq16, lt16;
    logic [15:0] a16, b16;
    logic [2:0]  cyc16;

    logic        iv4, ir4, sm4, ov4, or4, gt4, eq4, lt4;
    logic [3:0]  a4, b4;
    logic [2:0]  cyc4;

    seq_mag_comp #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .signed_mode(sm16), .out_valid(ov16), .out_ready(or16), .agtb(gt16), .aeqb(eq16),
        .altb(lt16), .out_cycles(cyc16));

    seq_mag_comp #(.WIDTH(4), .CHUNK(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .signed_mode(sm4), .out_valid(ov4), .out_ready(or4), .agtb(gt4), .aeqb(eq4),
        .altb(lt4), .out_cycles(cyc4));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: ordinary integer compare; cycles = chunks scanned from the MSB up to the first difference.
    function automatic void model(input int w, input int c, input logic [15:0] a, input logic [15:0] b,
                                  input bit sm, output logic [2:0] fl, output int cyc);
        longint va, vb, mask;
        int nch;
        nch  = w / c;
        mask = (longint'(1) << c) - 1;
        va   = longint'(a);
        vb   = longint'(b);
        if (sm && a[w-1]) va = va - (longint'(1) << w);
        if (sm && b[w-1]) vb = vb - (longint'(1) << w);
        fl  = {va > vb, va == vb, va < vb};
        cyc = 0;
        for (int i = nch - 1; i >= 0; i--) begin
            cyc++;
            if ((longint'(a >> (i * c)) & mask) != (longint'(b >> (i * c)) & mask)) break;
        end
    endfunction

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input bit sm, input string nm);
        @(negedge clk);
        chk({nm, "_in_ready"}, ir16, 1'b1);
        iv16 = 1'b1; a16 = a; b16 = b; sm16 = sm;
        @(negedge clk);
        iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
    endtask

    task automatic wait_valid16(output int lat);
        lat = 0;
        while (!ov16 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic txn16(input string nm, input logic [15:0] a, input logic [15:0] b, input bit sm,
                         input bit lit, input logic [2:0] lfl, input int lcyc);
        logic [2:0] efl;
        int ecyc, lat;
        model(16, 4, a, b, sm, efl, ecyc);
        if (lit) begin
            chk({nm, "_model_flags"}, efl, lfl);
            chk({nm, "_model_cycles"}, ecyc, lcyc);
        end
        start16(a, b, sm, nm);
        wait_valid16(lat);
        chk({nm, "_latency"}, lat, ecyc);
        chk({nm, "_flags"}, {gt16, eq16, lt16}, efl);
        chk({nm, "_out_cycles"}, cyc16, ecyc);
        chk({nm, "_busy"}, ir16, 1'b0);
        @(negedge clk);
        chk({nm, "_release"}, {ov16, ir16, gt16, eq16, lt16, cyc16}, {5'b01000, 3'd0});
    endtask

    logic [2:0] q_fl[$];
    int         q_cyc[$];
    bit         pv = 1'b0, pr = 1'b0;
    logic [6:0] pout = '0;

    // Checks dut4 outputs every cycle against expectations queued at accept time.
    always @(negedge clk) begin
        if (ov4) begin
            chk("dut4_onehot", $countones({gt4, eq4, lt4}), 1);
            if (or4) begin
                if (q_fl.size() == 0) begin
                    chk("dut4_unexpected_result", 1'b1, 1'b0);
                end else begin
                    chk("dut4_flags", {gt4, eq4, lt4}, q_fl.pop_front());
                    chk("dut4_cycles", cyc4, q_cyc.pop_front());
                end
            end
        end else begin
            chk("dut4_idle_zero", {gt4, eq4, lt4, cyc4}, 6'd0);
        end
        if (pv && !pr) chk("dut4_hold", {ov4, gt4, eq4, lt4, cyc4}, pout);
        pv   = ov4;
        pr   = or4;
        pout = {ov4, gt4, eq4, lt4, cyc4};
    end

    initial begin
        or4 = 1'b1;
        forever begin
            @(posedge clk);
            #1 or4 = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, w;
        logic [2:0] efl;
        int ecyc;

        rst_n = 1'b1;
        iv16 = 1'b0; a16 = '0; b16 = '0; sm16 = 1'b0; or16 = 1'b1;
        iv4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0;
        #1 rst_n = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_outputs16", {ir16, ov16, gt16, eq16, lt16, cyc16}, 8'd0);
        chk("reset_outputs4", {ir4, ov4, gt4, eq4, lt4, cyc4}, 8'd0);
        rst_n = 1'b1;
        #1;
        chk("release_ready", {ir16, ov16, ir4, ov4}, 4'b1010);

        txn16("u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 1'b1, 3'b100, 1);
        txn16("s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 1'b1, 3'b001, 1);
        txn16("eq_a5a5", 16'hA5A5, 16'hA5A5, 1'b0, 1'b1, 3'b010, 4);
        txn16("s_m1_1", 16'hFFFF, 16'h0001, 1'b1, 1'b1, 3'b001, 1);

        or16 = 1'b0;
        start16(16'h1234, 16'h1235, 1'b0, "bp");
        wait_valid16(lat);
        chk("bp_latency", lat, 4);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                iv16 = 1'b1; a16 = 16'h0000; b16 = 16'hFFFF; sm16 = 1'b0;
            end
            @(negedge clk);
            iv16 = 1'b0;
            chk("bp_hold", {ov16, gt16, eq16, lt16, cyc16}, {4'b1001, 3'd4});
            chk("bp_in_ready", ir16, 1'b0);
        end
        or16 = 1'b1;
        @(negedge clk);
        chk("bp_release", {ov16, ir16, gt16, eq16, lt16}, 5'b01000);
        repeat (5) @(negedge clk);
        chk("bp_pulse_ignored", {ov16, ir16}, 2'b01);

        start16(16'hA5A5, 16'hA5A5, 1'b0, "midrst");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {ir16, ov16, gt16, eq16, lt16, cyc16}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_idle", ir16, 1'b1);
        repeat (6) @(negedge clk);
        chk("midrst_discarded", {ov16, ir16}, 2'b01);
        txn16("after_rst", 16'h0010, 16'h0001, 1'b0, 1'b1, 3'b100, 3);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 1) != 0) ? (ra ^ (16'h1 << $urandom_range(0, 15))) : 16'($urandom);
            if (i % 8 == 0) rb = ra;
            txn16("rand16", ra, rb, 1'($urandom), 1'b0, 3'b000, 0);
        end

        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    @(posedge clk);
                    #1;
                    iv4 = 1'b1; a4 = 4'(x); b4 = 4'(y); sm4 = 1'(s);
                    w = 0;
                    @(negedge clk);
                    while (!ir4 && w < 50) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 50) chk("dut4_accept_timeout", w, 0);
                    model(4, 1, 16'(x), 16'(y), 1'(s), efl, ecyc);
                    q_fl.push_back(efl);
                    q_cyc.push_back(ecyc);
                    @(posedge clk);
                    #1;
                    iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
                end
            end
        end
        w = 0;
        while (q_fl.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("dut4_drain", q_fl.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
